// File: rtl/mapping_pkg.sv
// Shared definitions for the mapping request arbiter and its ID FIFOs.
package mapping_pkg;
  localparam int MAPPING_DATA_W    = 73;
  localparam int MAPPING_MAX_OUTST = 16;

  typedef enum logic {MAP_RD = 1'b0, MAP_WR = 1'b1} map_op_t;
endpackage

// File: rtl/mapping_id_fifo.sv
// Requester-ID FIFO for one mapping channel; tolerates push and pop in the same cycle, even when full.
module mapping_id_fifo #(
  parameter int IDW   = 2,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic [IDW-1:0] push_id,
  input  logic           pop,
  output logic [IDW-1:0] head,
  output logic [AW:0]    count
);
  localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [IDW-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           empty;
  logic           full;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_C);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end
endmodule

// File: rtl/mapping_req_arb.sv
// Round-robin request arbiter and response router in front of one mapping_ip_top.
// Optional per-requester grant counters are built when MAPPING_ARB_STATS_EN is defined.
module mapping_req_arb
  import mapping_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = MAPPING_DATA_W,
  parameter int MAX_OUTST = MAPPING_MAX_OUTST,
  parameter int IDW       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ*DATA_W-1:0] req_tdata,
  input  logic [NUM_REQ-1:0]        req_twrite,
  input  logic [NUM_REQ-1:0]        req_tvalid,
  output logic [NUM_REQ-1:0]        req_tready,
  output logic [DATA_W-1:0]         m_read_tdata,
  output logic                      m_read_tvalid,
  input  logic                      m_read_tready,
  output logic [DATA_W-1:0]         m_write_tdata,
  output logic                      m_write_tvalid,
  input  logic                      m_write_tready,
  input  logic [DATA_W-1:0]         s_rrsp_tdata,
  input  logic                      s_rrsp_tvalid,
  output logic                      s_rrsp_tready,
  input  logic [DATA_W-1:0]         s_wrsp_tdata,
  input  logic                      s_wrsp_tvalid,
  output logic                      s_wrsp_tready,
  output logic [DATA_W-1:0]         rsp_tdata,
  output logic [IDW-1:0]            rsp_tid,
  output logic                      rsp_twrite,
  output logic                      rsp_tvalid,
  input  logic                      rsp_tready,
  output logic                      err_orphan_rsp
`ifdef MAPPING_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [NUM_REQ*32-1:0]     stat_grants
`endif
);
  localparam int               CW     = $clog2(MAX_OUTST) + 1;
  localparam logic [CW-1:0]    FULL_C = CW'(MAX_OUTST);
  localparam logic [IDW-1:0]   LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]     NREQ_W  = (IDW+1)'(NUM_REQ);

  logic [IDW-1:0]     rd_head, wr_head;
  logic [CW-1:0]      rd_cnt, wr_cnt;
  logic               rd_empty, wr_empty, rd_full, wr_full;
  logic               load_ok, rd_take, wr_take, orphan;
  logic               rd_can, wr_can;
  logic [NUM_REQ-1:0] elig, grant;
  logic               gnt_any;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW:0]       scan;
  logic [DATA_W-1:0]  gnt_data;
  map_op_t            gnt_op;
  logic               rd_push, wr_push;

  assign rd_empty = (rd_cnt == '0);
  assign wr_empty = (wr_cnt == '0);
  assign rd_full  = (rd_cnt == FULL_C);
  assign wr_full  = (wr_cnt == FULL_C);

  // Response side: read wins the single response register; empty-FIFO responses are swallowed.
  assign load_ok       = ~rsp_tvalid | rsp_tready;
  assign s_rrsp_tready = rst_n & (rd_empty | load_ok);
  assign s_wrsp_tready = rst_n & (wr_empty | (load_ok & ~(s_rrsp_tvalid & ~rd_empty)));
  assign rd_take       = s_rrsp_tvalid & s_rrsp_tready & ~rd_empty;
  assign wr_take       = s_wrsp_tvalid & s_wrsp_tready & ~wr_empty;
  assign orphan        = (s_rrsp_tvalid & s_rrsp_tready & rd_empty) |
                         (s_wrsp_tvalid & s_wrsp_tready & wr_empty);

  // A full ID FIFO can still take a new ID when its head leaves in the same cycle.
  assign rd_can = rst_n & (~rd_full | rd_take) & (~m_read_tvalid | m_read_tready);
  assign wr_can = rst_n & (~wr_full | wr_take) & (~m_write_tvalid | m_write_tready);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_tvalid[i] & (req_twrite[i] ? wr_can : rd_can);
    end
  end

  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan >= NREQ_W) scan = scan - NREQ_W;
      if (!gnt_any && elig[scan[IDW-1:0]]) begin
        gnt_any                = 1'b1;
        gnt_id                 = scan[IDW-1:0];
        grant[scan[IDW-1:0]]   = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) gnt_data = req_tdata[i*DATA_W +: DATA_W];
    end
  end

  assign gnt_op     = map_op_t'(|(grant & req_twrite));
  assign rd_push    = gnt_any & (gnt_op == MAP_RD);
  assign wr_push    = gnt_any & (gnt_op == MAP_WR);
  assign req_tready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Request output registers: loaded on grant, cleared once the mapping block takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_read_tvalid  <= 1'b0;
      m_read_tdata   <= '0;
      m_write_tvalid <= 1'b0;
      m_write_tdata  <= '0;
    end else begin
      if (rd_push) begin
        m_read_tvalid <= 1'b1;
        m_read_tdata  <= gnt_data;
      end else if (m_read_tready) begin
        m_read_tvalid <= 1'b0;
      end
      if (wr_push) begin
        m_write_tvalid <= 1'b1;
        m_write_tdata  <= gnt_data;
      end else if (m_write_tready) begin
        m_write_tvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_tvalid     <= 1'b0;
      rsp_tdata      <= '0;
      rsp_tid        <= '0;
      rsp_twrite     <= 1'b0;
      err_orphan_rsp <= 1'b0;
    end else begin
      if (rd_take) begin
        rsp_tvalid <= 1'b1;
        rsp_tdata  <= s_rrsp_tdata;
        rsp_tid    <= rd_head;
        rsp_twrite <= MAP_RD;
      end else if (wr_take) begin
        rsp_tvalid <= 1'b1;
        rsp_tdata  <= s_wrsp_tdata;
        rsp_tid    <= wr_head;
        rsp_twrite <= MAP_WR;
      end else if (rsp_tready) begin
        rsp_tvalid <= 1'b0;
      end
      if (orphan) err_orphan_rsp <= 1'b1;
    end
  end

  mapping_id_fifo #(.IDW(IDW), .DEPTH(MAX_OUTST)) u_rd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (rd_push),
    .push_id (gnt_id),
    .pop     (rd_take),
    .head    (rd_head),
    .count   (rd_cnt)
  );

  mapping_id_fifo #(.IDW(IDW), .DEPTH(MAX_OUTST)) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (wr_push),
    .push_id (gnt_id),
    .pop     (wr_take),
    .head    (wr_head),
    .count   (wr_cnt)
  );

`ifdef MAPPING_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_REQ];

  // Clear beats a coincident grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr)      grant_cnt[i] <= '0;
        else if (grant[i]) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[i*32 +: 32] = grant_cnt[i];
  end
`endif
endmodule

// File: tb/tb_mapping_req_arb.sv
// Randomized bench for mapping_req_arb against a queue-based transaction model.
module tb_mapping_req_arb;
  localparam int N  = 4;
  localparam int DW = 73;
  localparam int MO = 16;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N*DW-1:0]   req_tdata = '0;
  logic [N-1:0]      req_twrite = '0;
  logic [N-1:0]      req_tvalid = '0;
  logic [N-1:0]      req_tready;
  logic [DW-1:0]     m_read_tdata;
  logic              m_read_tvalid;
  logic              m_read_tready = 1'b0;
  logic [DW-1:0]     m_write_tdata;
  logic              m_write_tvalid;
  logic              m_write_tready = 1'b0;
  logic [DW-1:0]     s_rrsp_tdata = '0;
  logic              s_rrsp_tvalid = 1'b0;
  logic              s_rrsp_tready;
  logic [DW-1:0]     s_wrsp_tdata = '0;
  logic              s_wrsp_tvalid = 1'b0;
  logic              s_wrsp_tready;
  logic [DW-1:0]     rsp_tdata;
  logic [IW-1:0]     rsp_tid;
  logic              rsp_twrite;
  logic              rsp_tvalid;
  logic              rsp_tready = 1'b0;
  logic              err_orphan_rsp;

  mapping_req_arb #(.NUM_REQ(N), .DATA_W(DW), .MAX_OUTST(MO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_tdata      (req_tdata),
    .req_twrite     (req_twrite),
    .req_tvalid     (req_tvalid),
    .req_tready     (req_tready),
    .m_read_tdata   (m_read_tdata),
    .m_read_tvalid  (m_read_tvalid),
    .m_read_tready  (m_read_tready),
    .m_write_tdata  (m_write_tdata),
    .m_write_tvalid (m_write_tvalid),
    .m_write_tready (m_write_tready),
    .s_rrsp_tdata   (s_rrsp_tdata),
    .s_rrsp_tvalid  (s_rrsp_tvalid),
    .s_rrsp_tready  (s_rrsp_tready),
    .s_wrsp_tdata   (s_wrsp_tdata),
    .s_wrsp_tvalid  (s_wrsp_tvalid),
    .s_wrsp_tready  (s_wrsp_tready),
    .rsp_tdata      (rsp_tdata),
    .rsp_tid        (rsp_tid),
    .rsp_twrite     (rsp_twrite),
    .rsp_tvalid     (rsp_tvalid),
    .rsp_tready     (rsp_tready),
    .err_orphan_rsp (err_orphan_rsp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: transactions held as values and queues of requester IDs.
  bit            m_rd_v, m_wr_v, m_rsp_v, m_rsp_w, m_err;
  logic [DW-1:0] m_rd_d, m_wr_d, m_rsp_d;
  int            m_rsp_id, m_ptr;
  int            rdq[$];
  int            wrq[$];

  bit            e_rrdy, e_wrdy, e_rtake, e_wtake;
  int            e_gnt;
  logic [N-1:0]  e_req_rdy;
  logic [N-1:0]  last_req_rdy;

  task automatic model_reset();
    m_rd_v = 0; m_wr_v = 0; m_rsp_v = 0; m_rsp_w = 0; m_err = 0;
    m_rd_d = '0; m_wr_d = '0; m_rsp_d = '0;
    m_rsp_id = 0; m_ptr = 0;
    rdq.delete();
    wrq.delete();
  endtask

  task automatic model_eval();
    bit load_ok, rd_has, wr_has, rd_can, wr_can;
    e_rrdy = 0; e_wrdy = 0; e_rtake = 0; e_wtake = 0; e_gnt = -1; e_req_rdy = '0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    load_ok = !m_rsp_v || rsp_tready;
    rd_has  = rdq.size() > 0;
    wr_has  = wrq.size() > 0;
    e_rrdy  = !rd_has || load_ok;
    e_rtake = s_rrsp_tvalid && rd_has && load_ok;
    e_wrdy  = !wr_has || (load_ok && !(s_rrsp_tvalid && rd_has));
    e_wtake = s_wrsp_tvalid && wr_has && e_wrdy;
    rd_can  = (rdq.size() < MO || e_rtake) && (!m_rd_v || m_read_tready);
    wr_can  = (wrq.size() < MO || e_wtake) && (!m_wr_v || m_write_tready);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (e_gnt < 0 && req_tvalid[i] && (req_twrite[i] ? wr_can : rd_can)) e_gnt = i;
    end
    if (e_gnt >= 0) e_req_rdy[e_gnt] = 1'b1;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (s_rrsp_tvalid && rdq.size() == 0) m_err = 1;
    if (s_wrsp_tvalid && wrq.size() == 0) m_err = 1;
    if (e_rtake) begin
      m_rsp_v = 1; m_rsp_d = s_rrsp_tdata; m_rsp_id = rdq.pop_front(); m_rsp_w = 0;
    end else if (e_wtake) begin
      m_rsp_v = 1; m_rsp_d = s_wrsp_tdata; m_rsp_id = wrq.pop_front(); m_rsp_w = 1;
    end else if (rsp_tready) begin
      m_rsp_v = 0;
    end
    if (m_rd_v && m_read_tready)  m_rd_v = 0;
    if (m_wr_v && m_write_tready) m_wr_v = 0;
    if (e_gnt >= 0) begin
      if (req_twrite[e_gnt]) begin
        m_wr_v = 1; m_wr_d = req_tdata[e_gnt*DW +: DW]; wrq.push_back(e_gnt);
      end else begin
        m_rd_v = 1; m_rd_d = req_tdata[e_gnt*DW +: DW]; rdq.push_back(e_gnt);
      end
      m_ptr = (e_gnt + 1) % N;
    end
  endtask

  task automatic compare_outputs();
    check_eq("req_tready",     128'(req_tready),     128'(e_req_rdy));
    check_eq("m_read_tvalid",  128'(m_read_tvalid),  128'(m_rd_v));
    check_eq("m_read_tdata",   128'(m_read_tdata),   128'(m_rd_d));
    check_eq("m_write_tvalid", 128'(m_write_tvalid), 128'(m_wr_v));
    check_eq("m_write_tdata",  128'(m_write_tdata),  128'(m_wr_d));
    check_eq("s_rrsp_tready",  128'(s_rrsp_tready),  128'(e_rrdy));
    check_eq("s_wrsp_tready",  128'(s_wrsp_tready),  128'(e_wrdy));
    check_eq("rsp_tvalid",     128'(rsp_tvalid),     128'(m_rsp_v));
    check_eq("rsp_tdata",      128'(rsp_tdata),      128'(m_rsp_d));
    check_eq("rsp_tid",        128'(rsp_tid),        128'(m_rsp_id));
    check_eq("rsp_twrite",     128'(rsp_twrite),     128'(m_rsp_w));
    check_eq("err_orphan_rsp", 128'(err_orphan_rsp), 128'(m_err));
  endtask

  // Inputs are driven at the falling edge; outputs are compared 1 time unit later.
  task automatic cycle();
    #1;
    model_eval();
    last_req_rdy = req_tready;
    compare_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic idle_inputs();
    req_tvalid = '0; req_twrite = '0;
    s_rrsp_tvalid = 1'b0; s_wrsp_tvalid = 1'b0;
    m_read_tready = 1'b1; m_write_tready = 1'b1; rsp_tready = 1'b1;
  endtask

  task automatic drive_rand(input int p_req, input int p_wr, input int p_mrdy,
                            input int p_rsp, input int p_out);
    for (int i = 0; i < N; i++) begin
      req_tvalid[i] = ($urandom_range(99) < p_req);
      req_twrite[i] = ($urandom_range(99) < p_wr);
      req_tdata[i*DW +: DW] = rand_data();
    end
    m_read_tready  = ($urandom_range(99) < p_mrdy);
    m_write_tready = ($urandom_range(99) < p_mrdy);
    s_rrsp_tvalid  = ($urandom_range(99) < p_rsp);
    s_wrsp_tvalid  = ($urandom_range(99) < p_rsp);
    s_rrsp_tdata   = rand_data();
    s_wrsp_tdata   = rand_data();
    rsp_tready     = ($urandom_range(99) < p_out);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] one_data;
    logic [DW-1:0] held;
    model_reset();
    idle_inputs();
    @(negedge clk);
    req_tvalid = '1;
    do_reset();

    // Orphan write response with an empty write FIFO
    idle_inputs();
    s_wrsp_tvalid = 1'b1;
    s_wrsp_tdata  = 73'h1234;
    cycle();
    check_eq("orphan_flag", 128'(err_orphan_rsp), 128'(1));
    check_eq("orphan_no_rsp", 128'(rsp_tvalid), 128'(0));
    idle_inputs();
    cycle();
    do_reset();
    check_eq("flag_cleared", 128'(err_orphan_rsp), 128'(0));

    // Single read from requester 2
    one_data = 73'h1_0000_0000_0000_0001;
    idle_inputs();
    req_tvalid = 4'b0100;
    req_tdata[2*DW +: DW] = one_data;
    cycle();
    check_eq("single_m_read_tvalid", 128'(m_read_tvalid), 128'(1));
    check_eq("single_m_read_tdata", 128'(m_read_tdata), 128'(one_data));
    idle_inputs();
    s_rrsp_tvalid = 1'b1;
    s_rrsp_tdata  = 73'h5;
    cycle();
    check_eq("single_rsp_tid", 128'(rsp_tid), 128'(2));
    check_eq("single_rsp_twrite", 128'(rsp_twrite), 128'(0));
    check_eq("single_rsp_tdata", 128'(rsp_tdata), 128'(5));
    idle_inputs();
    cycle();
    do_reset();

    // Fairness: all requesters reading continuously
    for (int k = 0; k < 12; k++) begin
      idle_inputs();
      req_tvalid = '1;
      for (int i = 0; i < N; i++) req_tdata[i*DW +: DW] = rand_data();
      s_rrsp_tvalid = (k > 0);
      s_rrsp_tdata  = rand_data();
      cycle();
      check_eq("fair_order", 128'(last_req_rdy), 128'(4'b0001 << (k % N)));
    end
    idle_inputs();
    s_rrsp_tvalid = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    do_reset();

    // Outstanding limit on the read channel
    for (int k = 0; k < MO; k++) begin
      idle_inputs();
      req_tvalid = 4'b0010;
      req_tdata[DW +: DW] = rand_data();
      cycle();
    end
    idle_inputs();
    req_tvalid = 4'b1010;
    req_twrite = 4'b1000;
    req_tdata[3*DW +: DW] = rand_data();
    cycle();
    check_eq("limit_stall_rd_grant_wr", 128'(last_req_rdy), 128'(4'b1000));
    idle_inputs();
    req_tvalid = 4'b0010;
    s_rrsp_tvalid = 1'b1;
    s_rrsp_tdata  = rand_data();
    cycle();
    check_eq("limit_one_slot", 128'(last_req_rdy), 128'(4'b0010));
    idle_inputs();
    req_tvalid = 4'b0010;
    cycle();
    check_eq("limit_refull", 128'(last_req_rdy), 128'(4'b0000));

    // Response collision: read first, write next cycle
    idle_inputs();
    s_rrsp_tvalid = 1'b1; s_rrsp_tdata = rand_data();
    s_wrsp_tvalid = 1'b1; s_wrsp_tdata = rand_data();
    cycle();
    check_eq("collide_first_rd", 128'(rsp_twrite), 128'(0));
    check_eq("collide_first_tid", 128'(rsp_tid), 128'(1));
    s_rrsp_tvalid = 1'b0;
    cycle();
    check_eq("collide_second_wr", 128'(rsp_twrite), 128'(1));
    check_eq("collide_second_tid", 128'(rsp_tid), 128'(3));

    // Backpressure on the merged response
    idle_inputs();
    s_rrsp_tvalid = 1'b1; s_rrsp_tdata = rand_data();
    cycle();
    held = rsp_tdata;
    rsp_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_rrsp_tdata = rand_data();
      cycle();
      check_eq("bp_rsp_stable", 128'(rsp_tdata), 128'(held));
    end
    rsp_tready = 1'b1;
    s_rrsp_tvalid = 1'b0;
    cycle();
    cycle();

    // Randomized phases with different pressure profiles
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 600; k++) begin
        case (ph)
          0: drive_rand(60, 40, 80, 50, 80);
          1: drive_rand(90, 20, 90, 10, 90);
          2: drive_rand(70, 50, 50, 70, 30);
          default: drive_rand(30, 50, 90, 90, 95);
        endcase
        cycle();
      end
      if (ph == 1) begin
        drive_rand(80, 50, 50, 50, 50);
        do_reset();
        check_eq("midreset_rsp_tvalid", 128'(rsp_tvalid), 128'(0));
      end
    end

    drive_rand(80, 50, 50, 50, 50);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_req_tready", 128'(req_tready), 128'(0));
    check_eq("async_rst_m_read_tvalid", 128'(m_read_tvalid), 128'(0));
    check_eq("async_rst_err", 128'(err_orphan_rsp), 128'(0));
    @(negedge clk);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
